// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths and grant encoding for the register-file write arbiter.
package reg_write_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, with
// set/clear ports and three combinational read ports.
module reg_scoreboard
    import reg_write_arbiter_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  Set_Valid,
    input  logic [REG_ADDR_W-1:0] Set_Reg,
    input  logic                  Clr_Valid,
    input  logic [REG_ADDR_W-1:0] Clr_Reg,
    input  logic [REG_ADDR_W-1:0] Rd_Reg_1,
    input  logic [REG_ADDR_W-1:0] Rd_Reg_2,
    input  logic [REG_ADDR_W-1:0] Rd_Reg_3,
    output logic                  Busy_1,
    output logic                  Busy_2,
    output logic                  Busy_3
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear is applied before set so a same-cycle issue keeps the bit pending.
    always_comb begin
        busy_d = busy_q;
        if (Clr_Valid) begin
            busy_d[Clr_Reg] = 1'b0;
        end
        if (Set_Valid && (Set_Reg != '0)) begin
            busy_d[Set_Reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign Busy_1 = busy_q[Rd_Reg_1] && (Rd_Reg_1 != '0);
    assign Busy_2 = busy_q[Rd_Reg_2] && (Rd_Reg_2 != '0);
    assign Busy_3 = busy_q[Rd_Reg_3] && (Rd_Reg_3 != '0);

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter between ALU and load-unit writebacks, with a registered
// register-file write port and a pending-write scoreboard for hazard detection.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter bit ALLOW_R0_WRITE = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  Alu_Valid,
    input  logic [REG_ADDR_W-1:0] Alu_Reg,
    input  logic [REG_DATA_W-1:0] Alu_Data,
    output logic                  Alu_Ready,
    input  logic                  Mem_Valid,
    input  logic [REG_ADDR_W-1:0] Mem_Reg,
    input  logic [REG_DATA_W-1:0] Mem_Data,
    output logic                  Mem_Ready,
    input  logic                  Issue_Valid,
    input  logic [REG_ADDR_W-1:0] Issue_Reg,
    input  logic [REG_ADDR_W-1:0] Read_Register_1,
    input  logic [REG_ADDR_W-1:0] Read_Register_2,
    output logic                  Hazard_1,
    output logic                  Hazard_2,
    output logic                  Issue_Hazard,
    output logic                  Sig_Reg_Write,
    output logic [REG_ADDR_W-1:0] Write_Register,
    output logic [REG_DATA_W-1:0] Write_Data
);

    grant_e                last_grant_q;
    logic                  accept;
    logic [REG_ADDR_W-1:0] acc_reg;
    logic [REG_DATA_W-1:0] acc_data;
    logic                  wr_en;

    // On a conflict the requester that did not win last time gets the port.
    always_comb begin
        Alu_Ready = Reset_N && Alu_Valid && (!Mem_Valid || (last_grant_q == GNT_MEM));
        Mem_Ready = Reset_N && Mem_Valid && (!Alu_Valid || (last_grant_q == GNT_ALU));
        accept    = Alu_Ready || Mem_Ready;
        acc_reg   = Alu_Ready ? Alu_Reg : Mem_Reg;
        acc_data  = Alu_Ready ? Alu_Data : Mem_Data;
        wr_en     = accept && ((acc_reg != '0) || ALLOW_R0_WRITE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            last_grant_q   <= GNT_MEM;
            Sig_Reg_Write  <= 1'b0;
            Write_Register <= '0;
            Write_Data     <= '0;
        end else begin
            Sig_Reg_Write <= wr_en;
            if (wr_en) begin
                Write_Register <= acc_reg;
                Write_Data     <= acc_data;
            end
            if (accept) begin
                last_grant_q <= Alu_Ready ? GNT_ALU : GNT_MEM;
            end
        end
    end

    reg_scoreboard u_scoreboard (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .Set_Valid (Issue_Valid),
        .Set_Reg   (Issue_Reg),
        .Clr_Valid (accept),
        .Clr_Reg   (acc_reg),
        .Rd_Reg_1  (Read_Register_1),
        .Rd_Reg_2  (Read_Register_2),
        .Rd_Reg_3  (Issue_Reg),
        .Busy_1    (Hazard_1),
        .Busy_2    (Hazard_2),
        .Busy_3    (Issue_Hazard)
    );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized scoreboard bench for reg_write_arbiter against a behavioural model.
module tb_reg_write_arbiter;

    localparam bit ALLOW = 1'b0;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        Alu_Valid = 1'b0;
    logic [4:0]  Alu_Reg = '0;
    logic [31:0] Alu_Data = '0;
    logic        Alu_Ready;
    logic        Mem_Valid = 1'b0;
    logic [4:0]  Mem_Reg = '0;
    logic [31:0] Mem_Data = '0;
    logic        Mem_Ready;
    logic        Issue_Valid = 1'b0;
    logic [4:0]  Issue_Reg = '0;
    logic [4:0]  Read_Register_1 = '0;
    logic [4:0]  Read_Register_2 = '0;
    logic        Hazard_1;
    logic        Hazard_2;
    logic        Issue_Hazard;
    logic        Sig_Reg_Write;
    logic [4:0]  Write_Register;
    logic [31:0] Write_Data;

    reg_write_arbiter #(
        .ALLOW_R0_WRITE (ALLOW)
    ) dut (
        .Clk             (Clk),
        .Reset_N         (Reset_N),
        .Alu_Valid       (Alu_Valid),
        .Alu_Reg         (Alu_Reg),
        .Alu_Data        (Alu_Data),
        .Alu_Ready       (Alu_Ready),
        .Mem_Valid       (Mem_Valid),
        .Mem_Reg         (Mem_Reg),
        .Mem_Data        (Mem_Data),
        .Mem_Ready       (Mem_Ready),
        .Issue_Valid     (Issue_Valid),
        .Issue_Reg       (Issue_Reg),
        .Read_Register_1 (Read_Register_1),
        .Read_Register_2 (Read_Register_2),
        .Hazard_1        (Hazard_1),
        .Hazard_2        (Hazard_2),
        .Issue_Hazard    (Issue_Hazard),
        .Sig_Reg_Write   (Sig_Reg_Write),
        .Write_Register  (Write_Register),
        .Write_Data      (Write_Data)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    bit          started = 1'b0;

    // Reference state: set of registers with a pending write, and whose turn it is.
    bit          pending[32];
    bit          alu_has_prio = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %h required %h", name, cyc, act, req);
        end
    endtask

    // Drive one cycle, check combinational outputs, then advance the model.
    task automatic drive(input bit rst_n, input bit av, input logic [4:0] ar,
                         input logic [31:0] ad, input bit mv, input logic [4:0] mr,
                         input logic [31:0] md, input bit iv, input logic [4:0] ir,
                         input logic [4:0] r1, input logic [4:0] r2);
        bit          alu_go;
        bit          mem_go;
        logic [4:0]  wr;
        logic [31:0] wd;
        wr_t         e;
        @(negedge Clk);
        Reset_N = rst_n; Alu_Valid = av; Alu_Reg = ar; Alu_Data = ad;
        Mem_Valid = mv; Mem_Reg = mr; Mem_Data = md;
        Issue_Valid = iv; Issue_Reg = ir; Read_Register_1 = r1; Read_Register_2 = r2;
        #1;
        alu_go = rst_n && av && (!mv || alu_has_prio);
        mem_go = rst_n && mv && (!av || !alu_has_prio);
        if (started) begin
            chk("alu_ready", 32'(Alu_Ready), 32'(alu_go));
            chk("mem_ready", 32'(Mem_Ready), 32'(mem_go));
            chk("hazard_1", 32'(Hazard_1), 32'(pending[r1] && r1 != 0));
            chk("hazard_2", 32'(Hazard_2), 32'(pending[r2] && r2 != 0));
            chk("issue_hazard", 32'(Issue_Hazard), 32'(pending[ir] && ir != 0));
        end
        if (!rst_n) begin
            foreach (pending[i]) pending[i] = 1'b0;
            alu_has_prio = 1'b1;
        end else begin
            if (alu_go || mem_go) begin
                wr = alu_go ? ar : mr;
                wd = alu_go ? ad : md;
                alu_has_prio = mem_go;
                pending[wr] = 1'b0;
                if (wr != 0 || ALLOW) begin
                    e.cyc = cyc + 1; e.r = wr; e.d = wd;
                    exp_q.push_back(e);
                end
            end
            if (iv && ir != 0) pending[ir] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the registered write port with the queue of expected writes.
    logic [4:0]  hold_reg;
    logic [31:0] hold_data;
    initial begin
        hold_reg = '0;
        hold_data = '0;
        forever begin
            @(posedge Clk);
            cyc++;
            #1;
            if (!Reset_N) begin
                started = 1'b1;
                hold_reg = '0;
                hold_data = '0;
                while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
                chk("reset_wen", 32'(Sig_Reg_Write), 32'd0);
            end else if (started) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    chk("missed_write", 32'd0, 32'd1);
                    void'(exp_q.pop_front());
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    hold_reg = exp_q[0].r;
                    hold_data = exp_q[0].d;
                    void'(exp_q.pop_front());
                    chk("write_en", 32'(Sig_Reg_Write), 32'd1);
                end else begin
                    chk("write_en_idle", 32'(Sig_Reg_Write), 32'd0);
                end
            end
            if (started) begin
                chk("write_reg", 32'(Write_Register), 32'(hold_reg));
                chk("write_data", Write_Data, hold_data);
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 3, 32'h55, 1, 4, 32'h66, 1, 6, 6, 6);
        // Single ALU write.
        drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Sustained conflict alternates grants.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            drive(1, 1, 1, 32'h100 + i, 1, 2, 32'h200 + i, 0, 0, 0, 0);
        idle(1);
        // RAW hazard set by issue, cleared by load writeback.
        drive(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        drive(1, 0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 7);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        // Same-cycle issue and writeback: set wins.
        drive(1, 1, 9, 32'h99, 0, 0, 0, 1, 9, 9, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 9, 9, 9);
        // Register 0 writes and issues are suppressed.
        drive(1, 1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset mid-stream drops the write and clears the scoreboard.
        drive(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 4, 3, 4);
        drive(1, 1, 8, 32'hA5, 0, 0, 0, 0, 0, 3, 4);
        drive(0, 1, 8, 32'hA6, 1, 10, 32'hB6, 0, 0, 3, 4);
        drive(1, 1, 11, 32'hC1, 1, 12, 32'hC2, 0, 4, 3, 4);
        drive(1, 1, 11, 32'hC3, 1, 12, 32'hC4, 0, 0, 3, 4);
        // Randomized traffic over a narrow register range to force collisions.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 63) != 0),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end
        idle(3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
